// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse packet assembler: frames the 3-byte movement packet from the byte
// receiver, decodes buttons and saturated 9-bit X/Y increments, and presents
// them to the consumer through a data_ready/read handshake.
module ps2_mouse_packet #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned TIMEOUT_WIDTH  = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       left_button,
  output logic       right_button,
  output logic       middle_button,
  output logic [8:0] x_increment,
  output logic [8:0] y_increment,
  output logic       data_ready,
  input  logic       read,
  output logic       sync_error,
  output logic       overrun
);

  localparam logic [7:0] BYTE_ACK       = 8'hFA;
  localparam logic [7:0] BYTE_SELF_TEST = 8'hAA;

  typedef enum logic [1:0] {
    S_BYTE0   = 2'd0,
    S_BYTE1   = 2'd1,
    S_BYTE2   = 2'd2,
    S_SKIP_ID = 2'd3
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  state_t                   w_state_eff;
  logic [TIMEOUT_WIDTH-1:0] r_cnt;
  logic [TIMEOUT_WIDTH-1:0] w_cnt_nxt;
  logic                     w_expired;
  logic                     w_latch_b0;
  logic                     w_latch_b1;
  logic                     w_complete;
  logic                     w_sync_err;

  // byte0 bits 7:4 (Yovf, Xovf, Ysign, Xsign) and 2:0 (buttons); bit3 is framing only
  logic [3:0]               r_b0_hi;
  logic [2:0]               r_b0_btn;
  logic [7:0]               r_b1;
  logic [8:0]               w_x;
  logic [8:0]               w_y;

  // Overflow clamps to the extreme of the indicated sign
  function automatic logic [8:0] sat9(input logic sign, input logic ovf, input logic [7:0] mag);
    if (ovf) begin
      return sign ? 9'h100 : 9'h0FF;
    end
    return {sign, mag};
  endfunction

  assign w_expired = (r_state != S_BYTE0) && (r_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES));
  assign w_x       = sat9(r_b0_hi[0], r_b0_hi[2], r_b1);
  assign w_y       = sat9(r_b0_hi[1], r_b0_hi[3], byte_in);

  // State and inter-byte timeout counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_BYTE0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state decode; an expired timeout makes the current byte (if any) a byte0
  always_comb begin
    w_state_nxt = r_state;
    w_state_eff = r_state;
    w_latch_b0  = 1'b0;
    w_latch_b1  = 1'b0;
    w_complete  = 1'b0;
    w_sync_err  = 1'b0;
    w_cnt_nxt   = r_cnt + TIMEOUT_WIDTH'(1);

    if (w_expired) begin
      w_state_eff = S_BYTE0;
      w_state_nxt = S_BYTE0;
      w_sync_err  = 1'b1;
    end

    if (byte_valid) begin
      case (w_state_eff)
        S_BYTE0: begin
          if (byte_in == BYTE_ACK) begin
            w_state_nxt = S_BYTE0;
          end else if (byte_in == BYTE_SELF_TEST) begin
            w_state_nxt = S_SKIP_ID;
          end else if (!byte_in[3]) begin
            w_sync_err  = 1'b1;
            w_state_nxt = S_BYTE0;
          end else begin
            w_latch_b0  = 1'b1;
            w_state_nxt = S_BYTE1;
          end
        end
        S_SKIP_ID: w_state_nxt = S_BYTE0;
        S_BYTE1: begin
          w_latch_b1  = 1'b1;
          w_state_nxt = S_BYTE2;
        end
        S_BYTE2: begin
          w_complete  = 1'b1;
          w_state_nxt = S_BYTE0;
        end
        default: w_state_nxt = S_BYTE0;
      endcase
    end

    if (byte_valid || (w_state_nxt == S_BYTE0)) begin
      w_cnt_nxt = '0;
    end
  end

  // Partial-packet byte registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_b0_hi  <= '0;
      r_b0_btn <= '0;
      r_b1     <= '0;
    end else begin
      if (w_latch_b0) begin
        r_b0_hi  <= byte_in[7:4];
        r_b0_btn <= byte_in[2:0];
      end
      if (w_latch_b1) begin
        r_b1 <= byte_in;
      end
    end
  end

  // Decoded packet outputs, handshake flag and status pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      left_button   <= 1'b0;
      right_button  <= 1'b0;
      middle_button <= 1'b0;
      x_increment   <= '0;
      y_increment   <= '0;
      data_ready    <= 1'b0;
      sync_error    <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      sync_error <= w_sync_err;
      overrun    <= w_complete && data_ready && !read;
      if (w_complete) begin
        left_button   <= r_b0_btn[0];
        right_button  <= r_b0_btn[1];
        middle_button <= r_b0_btn[2];
        x_increment   <= w_x;
        y_increment   <= w_y;
        data_ready    <= 1'b1;
      end else if (read) begin
        data_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Bench for ps2_mouse_packet: directed vector table, hand-written timeout /
// overrun / reset sequences and randomized traffic against a packet-level model.
module tb_ps2_mouse_packet;

  localparam int unsigned N = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       read;
  logic       left_button, right_button, middle_button;
  logic [8:0] x_increment, y_increment;
  logic       data_ready, sync_error, overrun;

  always #5 clk = ~clk;

  ps2_mouse_packet #(.TIMEOUT_CYCLES(N), .TIMEOUT_WIDTH(17)) dut (
    .clk           (clk),
    .reset         (reset),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .left_button   (left_button),
    .right_button  (right_button),
    .middle_button (middle_button),
    .x_increment   (x_increment),
    .y_increment   (y_increment),
    .data_ready    (data_ready),
    .read          (read),
    .sync_error    (sync_error),
    .overrun       (overrun)
  );

  // {data_ready, middle, right, left, x, y, sync_error, overrun}
  logic [23:0] w_dut;
  assign w_dut = {data_ready, middle_button, right_button, left_button,
                  x_increment, y_increment, sync_error, overrun};

  int n_vec = 0;
  int n_bad = 0;

  // Packet-level reference model
  int         pkt[$];
  bit         skip;
  int         age;
  logic       m_dr, m_se, m_ov;
  logic [2:0] m_btn;
  logic [8:0] m_x, m_y;

  function automatic logic [8:0] dec(int b0, int mag, int sb, int ob);
    int v;
    v = b0[sb] ? mag - 256 : mag;
    if (b0[ob]) v = b0[sb] ? -256 : 255;
    return 9'(v);
  endfunction

  function automatic logic [23:0] mbundle();
    return {m_dr, m_btn, m_x, m_y, m_se, m_ov};
  endfunction

  task automatic model_step(input bit rst, input bit bv, input int b, input bit rd);
    bit done;
    done = 1'b0;
    m_se = 1'b0;
    m_ov = 1'b0;
    if (rst) begin
      pkt.delete(); skip = 1'b0; age = 0;
      m_dr = 1'b0; m_btn = '0; m_x = '0; m_y = '0;
      return;
    end
    age++;
    if ((pkt.size() > 0 || skip) && age > int'(N)) begin
      pkt.delete(); skip = 1'b0; m_se = 1'b1;
    end
    if (bv) begin
      age = 0;
      if (skip) skip = 1'b0;
      else if (pkt.size() == 0) begin
        if (b == 'hFA) ;
        else if (b == 'hAA) skip = 1'b1;
        else if (b[3] == 1'b0) m_se = 1'b1;
        else pkt.push_back(b);
      end else begin
        pkt.push_back(b);
        if (pkt.size() == 3) done = 1'b1;
      end
    end
    if (done) begin
      if (m_dr && !rd) m_ov = 1'b1;
      m_btn = 3'(pkt[0] & 7);
      m_x   = dec(pkt[0], pkt[1], 4, 6);
      m_y   = dec(pkt[0], pkt[2], 5, 7);
      m_dr  = 1'b1;
      pkt.delete();
    end else if (rd) begin
      m_dr = 1'b0;
    end
  endtask

  task automatic cmp(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock with the given inputs; DUT compared against the model after the edge
  task automatic step(input bit rst, input bit bv, input logic [7:0] b, input bit rd);
    reset = rst; byte_valid = bv; byte_in = b; read = rd;
    @(posedge clk);
    #1;
    model_step(rst, bv, int'(b), rd);
    cmp("model", w_dut, mbundle());
    reset = 1'b0; byte_valid = 1'b0; read = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input bit rd_last);
    step(0, 1, a, 0);
    step(0, 1, b, 0);
    step(0, 1, c, rd_last);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 0);
  endtask

  typedef struct {
    bit          bv;
    logic [7:0]  b;
    bit          rd;
    logic [23:0] exp;
  } vec_t;

  function automatic vec_t v(bit bv, logic [7:0] b, bit rd, bit dr, logic [2:0] btn,
                             logic [8:0] x, logic [8:0] y, bit se, bit ov);
    vec_t t;
    t.bv = bv; t.b = b; t.rd = rd;
    t.exp = {dr, btn, x, y, se, ov};
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    int found;
    reset = 1'b1; byte_valid = 1'b0; byte_in = '0; read = 1'b0;

    tbl.push_back(v(1, 8'h29, 0, 0, 3'd0, 9'h000, 9'h000, 0, 0));
    tbl.push_back(v(1, 8'h05, 0, 0, 3'd0, 9'h000, 9'h000, 0, 0));
    tbl.push_back(v(1, 8'hF0, 0, 1, 3'd1, 9'h005, 9'h1F0, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 3'd1, 9'h005, 9'h1F0, 0, 0));
    tbl.push_back(v(1, 8'hFA, 0, 0, 3'd1, 9'h005, 9'h1F0, 0, 0));
    tbl.push_back(v(1, 8'hAA, 0, 0, 3'd1, 9'h005, 9'h1F0, 0, 0));
    tbl.push_back(v(1, 8'h00, 0, 0, 3'd1, 9'h005, 9'h1F0, 0, 0));
    tbl.push_back(v(1, 8'h08, 0, 0, 3'd1, 9'h005, 9'h1F0, 0, 0));
    tbl.push_back(v(1, 8'h10, 0, 0, 3'd1, 9'h005, 9'h1F0, 0, 0));
    tbl.push_back(v(1, 8'h20, 0, 1, 3'd0, 9'h010, 9'h020, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 3'd0, 9'h010, 9'h020, 0, 0));
    tbl.push_back(v(1, 8'h01, 0, 0, 3'd0, 9'h010, 9'h020, 1, 0));
    tbl.push_back(v(1, 8'h0A, 0, 0, 3'd0, 9'h010, 9'h020, 0, 0));
    tbl.push_back(v(1, 8'hFF, 0, 0, 3'd0, 9'h010, 9'h020, 0, 0));
    tbl.push_back(v(1, 8'h01, 0, 1, 3'd2, 9'h0FF, 9'h001, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 3'd2, 9'h0FF, 9'h001, 0, 0));
    tbl.push_back(v(1, 8'h58, 0, 0, 3'd2, 9'h0FF, 9'h001, 0, 0));
    tbl.push_back(v(1, 8'h12, 0, 0, 3'd2, 9'h0FF, 9'h001, 0, 0));
    tbl.push_back(v(1, 8'h00, 0, 1, 3'd0, 9'h100, 9'h000, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 3'd0, 9'h100, 9'h000, 0, 0));
    tbl.push_back(v(1, 8'h88, 0, 0, 3'd0, 9'h100, 9'h000, 0, 0));
    tbl.push_back(v(1, 8'h00, 0, 0, 3'd0, 9'h100, 9'h000, 0, 0));
    tbl.push_back(v(1, 8'h80, 0, 1, 3'd0, 9'h000, 9'h0FF, 0, 0));
    tbl.push_back(v(0, 8'h00, 1, 0, 3'd0, 9'h000, 9'h0FF, 0, 0));

    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    cmp("reset_state", w_dut, 24'h000000);

    foreach (tbl[i]) begin
      step(0, tbl[i].bv, tbl[i].b, tbl[i].rd);
      cmp($sformatf("table[%0d]", i), w_dut, tbl[i].exp);
    end

    // Timeout after two bytes of a packet
    step(0, 1, 8'h08, 0);
    step(0, 1, 8'h03, 0);
    found = -1;
    for (int i = 1; i <= int'(N) + 4; i++) begin
      step(0, 0, 8'h00, 0);
      if (sync_error && found < 0) found = i;
    end
    chk_int("timeout_cycle", found, int'(N) + 1);
    send3(8'h09, 8'h01, 8'h02, 0);
    cmp("after_timeout", w_dut, {1'b1, 3'd1, 9'h001, 9'h002, 1'b0, 1'b0});
    step(0, 0, 8'h00, 1);

    // Byte arriving on the last permitted cycle continues the packet
    step(0, 1, 8'h08, 0);
    idle(int'(N) - 1);
    step(0, 1, 8'h03, 0);
    idle(int'(N) - 1);
    step(0, 1, 8'h04, 0);
    cmp("gap_limit", w_dut, {1'b1, 3'd0, 9'h003, 9'h004, 1'b0, 1'b0});
    step(0, 0, 8'h00, 1);

    // Byte arriving on the expiry cycle becomes byte0
    step(0, 1, 8'h08, 0);
    idle(int'(N));
    step(0, 1, 8'h09, 0);
    cmp("expiry_byte0", w_dut, {1'b0, 3'd0, 9'h003, 9'h004, 1'b1, 1'b0});
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    cmp("expiry_packet", w_dut, {1'b1, 3'd1, 9'h001, 9'h002, 1'b0, 1'b0});
    step(0, 0, 8'h00, 1);

    // Overrun, then completion with simultaneous read
    send3(8'h08, 8'h05, 8'h06, 0);
    send3(8'h08, 8'h07, 8'h03, 0);
    cmp("overrun", w_dut, {1'b1, 3'd0, 9'h007, 9'h003, 1'b0, 1'b1});
    step(0, 0, 8'h00, 0);
    cmp("overrun_pulse_end", w_dut, {1'b1, 3'd0, 9'h007, 9'h003, 1'b0, 1'b0});
    send3(8'h09, 8'h02, 8'h02, 1);
    cmp("complete_with_read", w_dut, {1'b1, 3'd1, 9'h002, 9'h002, 1'b0, 1'b0});

    // Reset mid-packet
    step(0, 1, 8'h08, 0);
    step(1, 0, 8'h00, 0);
    cmp("reset_mid_packet", w_dut, 24'h000000);
    send3(8'h0A, 8'h03, 8'h04, 0);
    cmp("post_reset_packet", w_dut, {1'b1, 3'd2, 9'h003, 9'h004, 1'b0, 1'b0});

    // Randomized traffic against the model
    for (int i = 0; i < 900; i++) begin
      int r;
      bit bv;
      bit rd;
      logic [7:0] b;
      r  = int'($urandom_range(0, 99));
      rd = ($urandom_range(0, 4) == 0);
      if (r < 2) begin
        step(1, 0, 8'h00, 0);
      end else if (r < 5) begin
        idle(int'($urandom_range(N - 2, N + 3)));
      end else begin
        bv = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 9))
          0:       b = 8'hFA;
          1:       b = 8'hAA;
          2:       b = 8'h00;
          default: b = 8'($urandom);
        endcase
        step(0, bv, b, rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_packet.md
Name: ps2_mouse_packet

Overview:
Assembles the 3-byte PS/2 mouse movement packet from the PS/2 byte receiver's byte stream. Decodes buttons and 9-bit two's-complement X/Y increments from each packet. Presents them to the mouse state tracker through a data_ready/read handshake. Sits between the PS/2 byte receiver and the mouse state tracker. Discards protocol bytes (ACK, self-test) and resynchronises on framing errors and inter-byte timeouts.

Parameters:
TIMEOUT_CYCLES, 100000, clk cycles allowed between bytes of one packet before resync to byte 0.
TIMEOUT_WIDTH, 17, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
byte_in  input  8  received PS/2 byte, valid when byte_valid=1
byte_valid  input  1  one-cycle strobe per received byte
left_button  output  1  packet byte0 bit0
right_button  output  1  packet byte0 bit1
middle_button  output  1  packet byte0 bit2
x_increment  output  9  {byte0 bit4, byte1}, saturated on overflow
y_increment  output  9  {byte0 bit5, byte2}, saturated on overflow
data_ready  output  1  a decoded packet is held on the outputs
read  input  1  consumer acknowledge; one-cycle pulse
sync_error  output  1  one-cycle pulse when a byte is dropped for framing or timeout
overrun  output  1  one-cycle pulse when an unread packet is overwritten

Behaviour:
- Reset: state=S_BYTE0, timeout counter=0. All outputs 0: buttons, x_increment, y_increment, data_ready, sync_error, overrun.
- States: S_BYTE0, S_BYTE1, S_BYTE2, S_SKIP_ID. Transitions happen only on byte_valid, except timeout.
- S_BYTE0 on byte_valid:
  - byte_in=0xFA (ACK): discard, stay. No sync_error.
  - byte_in=0xAA (self-test pass): discard, go S_SKIP_ID.
  - byte_in bit3=0: discard, pulse sync_error, stay.
  - Otherwise: latch byte0 into an internal register, go S_BYTE1.
- S_SKIP_ID: the next byte (device ID, normally 0x00) is discarded. Go S_BYTE0.
- S_BYTE1: latch byte1, go S_BYTE2.
- S_BYTE2: packet complete, go S_BYTE0. On the next clock edge the output registers load, so data_ready rises 1 cycle after the third byte_valid.
- Output decode:
  - x_increment = {b0[4], b1}. If b0[6] (X overflow) is set: 9'h0FF when sign=0, 9'h100 when sign=1.
  - y_increment = {b0[5], b2}. If b0[7] (Y overflow) is set: same saturation.
  - Buttons come straight from b0[2:0].
- Timeout: counter clears on every byte_valid and is held at 0 in S_BYTE0. In S_BYTE1/S_BYTE2/S_SKIP_ID it increments each cycle without byte_valid. On reaching TIMEOUT_CYCLES: go S_BYTE0, pulse sync_error, discard the partial packet. A byte_valid in the same cycle as expiry is treated as byte0.
- Handshake:
  - Outputs are stable while data_ready=1.
  - read=1 while data_ready=1 clears data_ready on that edge.
  - read while data_ready=0 is ignored.
- Simultaneous events:
  - Completion together with read: the new packet loads and data_ready stays 1. No overrun.
  - Completion while data_ready=1 and no read: new packet overwrites the old one, data_ready stays 1, overrun pulses.
- Reset mid-packet aborts the partial packet and clears any pending data_ready.
- sync_error and overrun are registered pulses, 1 cycle wide.

Test Plan:
1. Bytes 0x29, 0x05, 0xF0 → 1 cycle after the 3rd strobe: data_ready=1, left=1, right=0, middle=0, x_increment=9'h005, y_increment=9'h1F0. Pulse read → data_ready=0 next cycle.
2. Bytes 0xFA, then 0xAA, 0x00, then packet 0x08, 0x10, 0x20 → no sync_error. Single packet with x=9'h010, y=9'h020, buttons 0.
3. Framing: 0x01 (bit3=0) → sync_error pulse, byte dropped. Following packet 0x0A, 0xFF, 0x01 → right=1, x=9'h0FF, y=9'h001.
4. Overflow: 0x58 (Xovf=1, Xsign=1), 0x12, 0x00 → x_increment=9'h100, y_increment=9'h000.
5. Timeout: 0x08, 0x03, then idle TIMEOUT_CYCLES → sync_error pulse. Next packet 0x09, 0x01, 0x02 → left=1, x=1, y=2.
6. Two full packets without read → overrun pulse, second packet's values held. Repeat with read on the completion cycle → no overrun, data_ready stays 1. Assert reset mid-packet → data_ready=0, state S_BYTE0.
